// File: rtl/ro_stress_pkg.sv
// ro_stress_pkg: shared definitions for the ring-oscillator stress array.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Used by the RO array top, the host register block and ro_enable_sequencer.
package ro_stress_pkg;

  // 150 oscillators split into banks of ten.
  localparam int NUM_BANKS_DEF = 15;
  localparam int ROS_PER_BANK  = 10;

  // Sequencer FSM states. Encoding kept fixed so the register block can
  // expose it as a raw status field.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ro_pwm_gate.sv
// ro_pwm_gate: free-running PWM counter with an on-time compare.
// Latency: gate is combinational from the counter register; counter advances every clk.
// Backpressure: none, the counter never stalls.
// Ports: clk, rst (async active-high), duty (on-time per 2^PWM_W period,
//        all-ones means continuously on), gate (high during the on-time).
module ro_pwm_gate #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty,
  output logic             gate
);

  logic [PWM_W-1:0] pwm_cnt_q;
  logic [PWM_W-1:0] pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // All-ones duty would otherwise leave one off cycle per period.
  always_comb begin
    gate = (&duty) | (pwm_cnt_q < duty);
  end

endmodule

// File: rtl/ro_enable_sequencer.sv
// ro_enable_sequencer: ramps the number of enabled RO banks one at a time and
//   duty-cycles the enabled set, so supply current steps instead of jumping.
// Latency: active_count moves every `step` cycles; bank_en follows one cycle later.
// Backpressure: cfg_ready is low while ramping; config is only taken in IDLE/HOLD.
// Ports: clk, rst (async active-high); cfg_valid/cfg_ready with cfg_target,
//        cfg_step_cycles, cfg_duty; start, stop; bank_en to the RO array;
//        active_count, busy, done status back to the register block.
module ro_enable_sequencer
  import ro_stress_pkg::*;
#(
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int CNT_W     = $clog2(NUM_BANKS + 1),
  parameter int STEP_W    = 24,
  parameter int PWM_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_W-1:0]     cfg_target,
  input  logic [STEP_W-1:0]    cfg_step_cycles,
  input  logic [PWM_W-1:0]     cfg_duty,
  input  logic                 start,
  input  logic                 stop,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic [CNT_W-1:0]     active_count,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0]  BANKS_MAX = CNT_W'(NUM_BANKS);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  seq_state_e           state_q,  state_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic [CNT_W-1:0]     goal_q,   goal_d;
  logic [CNT_W-1:0]     target_q, target_d;
  logic [STEP_W-1:0]    step_q,   step_d;
  logic [STEP_W-1:0]    timer_q,  timer_d;
  logic [PWM_W-1:0]     duty_q,   duty_d;
  logic                 done_q,   done_d;
  logic [NUM_BANKS-1:0] bank_en_q, bank_en_d;

  logic             cfg_hs;
  logic             step_tick;
  logic             pwm_on;
  logic [CNT_W-1:0] cfg_tgt_clamp;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] count_dec;
  logic [CNT_W-1:0] down_goal;

  ro_pwm_gate #(
    .PWM_W (PWM_W)
  ) u_pwm_gate (
    .clk  (clk),
    .rst  (rst),
    .duty (duty_q),
    .gate (pwm_on)
  );

  always_comb begin
    cfg_ready     = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    cfg_hs        = cfg_valid && cfg_ready;
    cfg_tgt_clamp = (cfg_target > BANKS_MAX) ? BANKS_MAX : cfg_target;
    // step_q is never 0, so step_q-1 cannot wrap.
    step_tick     = (timer_q >= (step_q - STEP_ONE));
    count_inc     = count_q + CNT_W'(1);
    count_dec     = count_q - CNT_W'(1);
    // A stop while already ramping down only retargets the goal.
    down_goal     = stop ? '0 : goal_q;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    goal_d   = goal_q;
    timer_d  = timer_q;
    done_d   = 1'b0;
    target_d = target_q;
    step_d   = step_q;
    duty_d   = duty_q;

    // Config capture is independent of the FSM decision, so a write that
    // coincides with stop in HOLD still lands in the stored registers.
    if (cfg_hs) begin
      target_d = cfg_tgt_clamp;
      step_d   = (cfg_step_cycles == '0) ? STEP_ONE : cfg_step_cycles;
      duty_d   = cfg_duty;
    end

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (start) begin
          if (target_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RAMP_UP;
            goal_d  = target_q;
          end
        end
      end

      ST_RAMP_UP: begin
        if (stop) begin
          goal_d  = '0;
          timer_d = '0;
          // Stopped before the first bank came on: nothing to ramp down.
          if (count_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RAMP_DOWN;
          end
        end else if (step_tick) begin
          timer_d = '0;
          if (count_q < BANKS_MAX) begin
            count_d = count_inc;
          end
          if (count_inc >= goal_q) begin
            state_d = ST_HOLD;
          end
        end else begin
          timer_d = timer_q + STEP_ONE;
        end
      end

      ST_HOLD: begin
        timer_d = '0;
        if (stop) begin
          state_d = ST_RAMP_DOWN;
          goal_d  = '0;
        end else if (cfg_hs) begin
          if (cfg_tgt_clamp > count_q) begin
            state_d = ST_RAMP_UP;
            goal_d  = cfg_tgt_clamp;
          end else if (cfg_tgt_clamp < count_q) begin
            state_d = ST_RAMP_DOWN;
            goal_d  = cfg_tgt_clamp;
          end
        end
      end

      ST_RAMP_DOWN: begin
        goal_d = down_goal;
        if (step_tick) begin
          timer_d = '0;
          if (count_q != '0) begin
            count_d = count_dec;
          end
          if (count_dec <= down_goal) begin
            if (down_goal == '0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end else begin
          timer_d = timer_q + STEP_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Thermometer decode: low banks fill first and the top bank drops first.
  always_comb begin
    bank_en_d = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_en_d[i] = pwm_on && (CNT_W'(i) < count_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      goal_q    <= '0;
      target_q  <= '0;
      step_q    <= STEP_ONE;
      timer_q   <= '0;
      duty_q    <= '0;
      done_q    <= 1'b0;
      bank_en_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      goal_q    <= goal_d;
      target_q  <= target_d;
      step_q    <= step_d;
      timer_q   <= timer_d;
      duty_q    <= duty_d;
      done_q    <= done_d;
      bank_en_q <= bank_en_d;
    end
  end

  always_comb begin
    bank_en      = bank_en_q;
    active_count = count_q;
    busy         = (state_q != ST_IDLE);
    done         = done_q;
  end

endmodule
